// File: rtl/data_mem_responder_if.sv
// Core-side data-memory port: request strobe, write flag, byte address and write data
// toward memory; registered read data, valid strobe and in-flight status back to the core.
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           data_in;
  logic [15:0]           data_out;
  logic                  data_valid;
  logic                  busy;
  logic [3:0]            outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy, outstanding
  );
endinterface

// File: rtl/data_mem_responder.sv
// Pipelined word memory: writes commit at acceptance, reads return LATENCY cycles later.
// One request per cycle, no backpressure; busy/outstanding report reads still in flight.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  mem_bus
);

  localparam int WORDS = 1 << (ADDR_WIDTH - 1);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..8");
  end

  logic [15:0]           r_mem [WORDS];
  logic [LATENCY-1:0]    r_vld;
  logic [15:0]           r_dat [LATENCY];
  logic [3:0]            r_outstanding;
  logic                  r_busy;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_exit;
  logic [ADDR_WIDTH-2:0] w_idx;
  logic [3:0]            w_out_nxt;
  logic                  w_unused_addr0;

  assign w_idx          = mem_bus.addr[ADDR_WIDTH-1:1];
  assign w_unused_addr0 = mem_bus.addr[0];
  assign w_rd_acc       = mem_bus.enable & ~mem_bus.wr;
  // Storage is not under reset, so request gating during reset must be explicit here.
  assign w_wr_acc       = mem_bus.enable & mem_bus.wr & rst_n;
  assign w_exit         = r_vld[LATENCY-1];

  always_comb begin
    w_out_nxt = r_outstanding + {3'b000, w_rd_acc} - {3'b000, w_exit};
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_idx] <= mem_bus.data_in;
    end
  end

  // Data stages only advance behind a valid word, so the last stage holds the
  // most recently returned word between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld         <= '0;
      r_outstanding <= 4'd0;
      r_busy        <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        r_dat[i] <= 16'h0000;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= r_mem[w_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
      r_outstanding <= w_out_nxt;
      r_busy        <= (w_out_nxt != 4'd0);
    end
  end

  assign mem_bus.data_out    = r_dat[LATENCY-1];
  assign mem_bus.data_valid  = r_vld[LATENCY-1];
  assign mem_bus.busy        = r_busy;
  assign mem_bus.outstanding = r_outstanding;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at LATENCY=4 and LATENCY=1: directed table, hand sequences,
// and randomized traffic checked every cycle against a cycle-scheduled reference model.
module tb_data_mem_responder;

  localparam int AW = 16;

  typedef struct packed {
    bit          en;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] din;
    bit          ev;
    logic [15:0] ed;
    logic [3:0]  eo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4_n;
  logic rst1_n;

  data_mem_responder_if #(.ADDR_WIDTH(AW)) bus4 ();
  data_mem_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst4_n),
    .mem_bus (bus4)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst1_n),
    .mem_bus (bus1)
  );

  int  n_cmp    = 0;
  int  n_bad    = 0;
  int  edge_cnt = 0;
  bit  chk_on   = 1'b0;

  // Reference model: a word array per DUT and a schedule of responses keyed by the
  // edge whose following cycle must show them.
  logic [15:0] mdl_mem  [2][32768];
  bit          sch_vld  [2][16];
  logic [15:0] sch_dat  [2][16];
  logic [15:0] mdl_dout [2];
  logic [15:0] pool_dat [16];

  function automatic int lat(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic vec_t v(bit en, bit wr, logic [15:0] a, logic [15:0] din,
                             bit ev, logic [15:0] ed, logic [3:0] eo);
    vec_t r;
    r.en = en; r.wr = wr; r.addr = a; r.din = din; r.ev = ev; r.ed = ed; r.eo = eo;
    return r;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int d, logic rv, logic en, logic wr,
                            logic [15:0] a, logic [15:0] din);
    int due;
    if (!rv) begin
      for (int k = 0; k < 16; k++) sch_vld[d][k] = 1'b0;
      mdl_dout[d] = 16'h0000;
    end else if (en) begin
      if (wr) begin
        mdl_mem[d][a >> 1] = din;
      end else begin
        due = edge_cnt + lat(d) - 1;
        sch_vld[d][due % 16] = 1'b1;
        sch_dat[d][due % 16] = mdl_mem[d][a >> 1];
      end
    end
  endtask

  task automatic check_dut(int d, logic rv, logic vld, logic [15:0] dout,
                           logic bsy, logic [3:0] outs);
    int    slot;
    int    cnt;
    bit    ev;
    string tag;
    slot = edge_cnt % 16;
    cnt  = 0;
    ev   = 1'b0;
    tag  = (d == 0) ? "L4" : "L1";
    if (!rv) begin
      for (int k = 0; k < 16; k++) sch_vld[d][k] = 1'b0;
      mdl_dout[d] = 16'h0000;
    end else begin
      for (int k = 0; k < 16; k++) cnt += int'(sch_vld[d][k]);
      ev = sch_vld[d][slot];
      if (ev) mdl_dout[d] = sch_dat[d][slot];
      sch_vld[d][slot] = 1'b0;
    end
    cmp({tag, ".data_valid"},  vld,  ev);
    cmp({tag, ".data_out"},    dout, mdl_dout[d]);
    cmp({tag, ".busy"},        bsy,  cnt != 0);
    cmp({tag, ".outstanding"}, outs, cnt);
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    model_step(0, rst4_n, bus4.enable, bus4.wr, bus4.addr, bus4.data_in);
    model_step(1, rst1_n, bus1.enable, bus1.wr, bus1.addr, bus1.data_in);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_dut(0, rst4_n, bus4.data_valid, bus4.data_out, bus4.busy, bus4.outstanding);
      check_dut(1, rst1_n, bus1.data_valid, bus1.data_out, bus1.busy, bus1.outstanding);
    end
  end

  task automatic drv4(bit en, bit wr, logic [15:0] a, logic [15:0] din);
    bus4.enable = en; bus4.wr = wr; bus4.addr = a; bus4.data_in = din;
  endtask

  task automatic drv1(bit en, bit wr, logic [15:0] a, logic [15:0] din);
    bus1.enable = en; bus1.wr = wr; bus1.addr = a; bus1.data_in = din;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pool_addr(int i);
    return 16'h0200 + 16'(2 * i);
  endfunction

  initial begin
    vec_t tbl[$];
    bit   saw;
    int   idx;

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) sch_vld[d][k] = 1'b0;
      mdl_dout[d] = 16'h0000;
    end
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    drv4(0, 0, 16'h0, 16'h0);
    drv1(0, 0, 16'h0, 16'h0);

    // Reset then idle
    cyc();
    chk_on = 1'b1;
    cyc();
    cmp("rst.data_valid",  bus4.data_valid, 0);
    cmp("rst.busy",        bus4.busy, 0);
    cmp("rst.outstanding", bus4.outstanding, 0);
    cmp("rst.data_out",    bus4.data_out, 16'h0000);
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) cyc();

    for (int i = 0; i < 16; i++) begin
      pool_dat[i] = 16'($urandom);
      drv4(1, 1, pool_addr(i), pool_dat[i]);
      drv1(1, 1, pool_addr(i), pool_dat[i]);
      cyc();
    end
    drv4(0, 0, 16'h0, 16'h0);
    drv1(0, 0, 16'h0, 16'h0);
    cyc();

    // Directed LATENCY=4 vectors: expected outputs after the edge applying each row.
    tbl.push_back(v(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1));
    tbl.push_back(v(1, 0, 16'h0011, 16'h0000, 0, 16'hBEEF, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1));
    tbl.push_back(v(1, 1, 16'h0100, 16'h1111, 0, 16'hBEEF, 0));
    tbl.push_back(v(1, 1, 16'h0102, 16'h2222, 0, 16'hBEEF, 0));
    tbl.push_back(v(1, 1, 16'h0104, 16'h3333, 0, 16'hBEEF, 0));
    tbl.push_back(v(1, 0, 16'h0100, 16'h0000, 0, 16'hBEEF, 1));
    tbl.push_back(v(1, 0, 16'h0102, 16'h0000, 0, 16'hBEEF, 2));
    tbl.push_back(v(1, 0, 16'h0104, 16'h0000, 0, 16'hBEEF, 3));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 3));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h2222, 2));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h3333, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h3333, 0));
    tbl.push_back(v(1, 1, 16'h0020, 16'hAAAA, 0, 16'h3333, 0));
    tbl.push_back(v(1, 0, 16'h0020, 16'h0000, 0, 16'h3333, 1));
    tbl.push_back(v(1, 1, 16'h0020, 16'h5555, 0, 16'h3333, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h3333, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'hAAAA, 1));
    tbl.push_back(v(1, 0, 16'h0020, 16'h0000, 0, 16'hAAAA, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'hAAAA, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'hAAAA, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h5555, 1));
    tbl.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h5555, 0));

    foreach (tbl[k]) begin
      drv4(tbl[k].en, tbl[k].wr, tbl[k].addr, tbl[k].din);
      cyc();
      cmp($sformatf("tbl[%0d].data_valid", k),  bus4.data_valid,  tbl[k].ev);
      cmp($sformatf("tbl[%0d].outstanding", k), bus4.outstanding, tbl[k].eo);
      cmp($sformatf("tbl[%0d].busy", k),        bus4.busy,        tbl[k].eo != 0);
      if (tbl[k].ev) cmp($sformatf("tbl[%0d].data_out", k), bus4.data_out, tbl[k].ed);
    end

    // Reset while two reads are in flight
    drv4(1, 0, 16'h0010, 16'h0);
    cyc();
    drv4(1, 0, 16'h0100, 16'h0);
    cyc();
    drv4(0, 0, 16'h0, 16'h0);
    cyc();
    rst4_n = 1'b0;
    #1;
    cmp("midrst.outstanding", bus4.outstanding, 0);
    cmp("midrst.busy",        bus4.busy, 0);
    cmp("midrst.data_out",    bus4.data_out, 16'h0000);
    cyc();
    cyc();
    rst4_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      cyc();
      if (bus4.data_valid) saw = 1'b1;
    end
    cmp("midrst.dropped_valid", saw, 0);
    drv4(1, 0, 16'h0010, 16'h0);
    cyc();
    drv4(0, 0, 16'h0, 16'h0);
    repeat (3) cyc();
    cmp("midrst.after.data_valid", bus4.data_valid, 1);
    cmp("midrst.after.data_out",   bus4.data_out, 16'hBEEF);
    repeat (2) cyc();

    // LATENCY=1: read-after-write and continuous reads
    drv1(1, 1, 16'h0010, 16'h00C3);
    cyc();
    drv1(1, 0, 16'h0010, 16'h0);
    cyc();
    cmp("l1.raw.data_valid",  bus1.data_valid, 1);
    cmp("l1.raw.data_out",    bus1.data_out, 16'h00C3);
    cmp("l1.raw.outstanding", bus1.outstanding, 1);
    for (int i = 0; i < 8; i++) begin
      drv1(1, 0, pool_addr(i), 16'h0);
      cyc();
      cmp($sformatf("l1.stream[%0d].data_valid", i),  bus1.data_valid, 1);
      cmp($sformatf("l1.stream[%0d].outstanding", i), bus1.outstanding, 1);
      cmp($sformatf("l1.stream[%0d].data_out", i),    bus1.data_out, pool_dat[i]);
    end
    drv1(0, 0, 16'h0, 16'h0);
    cyc();
    cmp("l1.idle.data_valid",  bus1.data_valid, 0);
    cmp("l1.idle.outstanding", bus1.outstanding, 0);
    cmp("l1.idle.busy",        bus1.busy, 0);

    // Randomized traffic on both instances, occasional resets on the LATENCY=4 one
    for (int n = 0; n < 3000; n++) begin
      idx = int'($urandom_range(0, 15));
      drv4($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           pool_addr(idx) + 16'($urandom_range(0, 1)), 16'($urandom));
      idx = int'($urandom_range(0, 15));
      drv1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           pool_addr(idx) + 16'($urandom_range(0, 1)), 16'($urandom));
      rst4_n = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst4_n = 1'b1;
    drv4(0, 0, 16'h0, 16'h0);
    drv1(0, 0, 16'h0, 16'h0);
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle, pipelined data-memory responder. It services the word read/write requests the CPU core issues on its data-memory port (enable, wr, addr, data_in).
- Replaces the single-cycle data memory model for the pipelined CPU phase.
- Accepts one request per cycle and returns read data a fixed LATENCY cycles later with a valid strobe.
- Writes commit in the acceptance cycle. A busy flag tells the core's stall logic that reads are in flight.

Parameters:
- ADDR_WIDTH, 16: byte-address width. Storage is 2^(ADDR_WIDTH-1) 16-bit words, word index = addr[ADDR_WIDTH-1:1].
- LATENCY, 4: cycles from read acceptance to data_valid. Legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  request strobe. A request is accepted on every rising edge with enable=1.
- wr  input  1  1 = write, 0 = read. Ignored when enable=0.
- addr  input  ADDR_WIDTH  byte address. addr[0] is ignored (word aligned).
- data_in  input  16  write data
- data_out  output  16  read data, meaningful only while data_valid=1
- data_valid  output  1  one-cycle pulse per accepted read, LATENCY cycles after acceptance
- busy  output  1  1 while any accepted read has not yet produced data_valid
- outstanding  output  4  count of in-flight reads, 0..LATENCY

Behaviour:
- Reset (async, rst_n=0):
  - Pipeline valid bits, data_valid, busy and outstanding go to 0; data_out goes to 16'h0000.
  - Storage array contents are NOT reset and keep their values across reset.
  - Reads that were in flight are dropped and never produce data_valid.
  - Requests presented while rst_n=0 are ignored.
- Acceptance: at the posedge with enable=1 and rst_n=1.
  - Write (wr=1): mem[addr[ADDR_WIDTH-1:1]] <= data_in at that edge. No response pulse.
  - Read (wr=0): the word is sampled from storage at that edge and pushed into stage 1 of a LATENCY-deep valid/data shift pipeline.
- Latency: a read accepted at edge N drives data_valid=1 and data_out=word during the cycle following edge N+LATENCY-1.
  - With LATENCY=1 this is the cycle right after acceptance.
  - data_valid is registered (no combinational path from inputs).
- Throughput: back-to-back reads on consecutive edges give back-to-back data_valid pulses, in order. There is no backpressure.
- Ordering and hazards:
  - A read accepted at the edge after a write to the same word returns the new data.
  - A read cannot coincide with a write, since there is one request per cycle.
  - A write landing while an older read to the same word is in flight does NOT alter that read's data; data is captured at acceptance.
- data_out:
  - Holds the last returned word after data_valid drops.
  - Updates only on a pipeline-exit cycle.
  - Reset value 16'h0000.
- outstanding:
  - Increments on read acceptance and decrements on pipeline exit.
  - A simultaneous accept and exit leaves it unchanged.
  - It never exceeds LATENCY. The width is fixed at 4 bits, sufficient for LATENCY<=8.
- busy = (outstanding != 0), registered-equivalent.
  - Goes 1 the cycle after a read is accepted.
  - Goes 0 in the cycle after the last data_valid.
- Address wrap: only the low ADDR_WIDTH bits are used, and upper-word aliasing does not occur at ADDR_WIDTH=16.
- Unknowns: enable=X while rst_n=1 is a bench error. The design does not need to filter it.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, enable=0 → data_valid=0, busy=0, outstanding=0, data_out=16'h0000 throughout.
- Write/read: write 16'hBEEF @0x0010, read @0x0010 next edge (LATENCY=4) → data_valid pulses exactly 4 cycles after the read edge, data_out=16'hBEEF. Read @0x0011 returns the same word.
- Streaming: write 16'h1111, 16'h2222, 16'h3333 to 0x0100/0x0102/0x0104, then three consecutive reads → three consecutive data_valid cycles with data 1111, 2222, 3333 in order. outstanding peaks at 3 and busy drops the cycle after the third pulse.
- Write-behind-read: mem[0x0020]=16'hAAAA, read @0x0020, next edge write 16'h5555 @0x0020 → response is 16'hAAAA. A subsequent read returns 16'h5555.
- Reset mid-flight: issue 2 reads, assert rst_n low 2 cycles later → no data_valid ever appears for them, and outstanding=0 immediately. Afterwards a read of the earlier-written word still returns its pre-reset value.
- LATENCY=1 build: read @0x0010 after writing 16'h00C3 → data_valid in the very next cycle with 16'h00C3. Continuous reads give data_valid high every cycle and outstanding=1 steady.
